// File: rtl/mram_pwr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mram_pwr_pkg
//  Description : Shared types and constants for the MRAM power-rail
//                sequencer: state encoding, per-state output decode and
//                the default step-delay counter width.
//  Ports       : none (package)
//  Options     : none
//  Revision    : 1.0  initial release
// ============================================================================
package mram_pwr_pkg;

    localparam int CNT_WIDTH_DEF = 8;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_UP_VDD  = 4'd1,
        ST_UP_VDDA = 4'd2,
        ST_UP_VREF = 4'd3,
        ST_UP_ISO  = 4'd4,
        ST_ON      = 4'd5,
        ST_DN_ISO  = 4'd6,
        ST_DN_VREF = 4'd7,
        ST_DN_VDDA = 4'd8,
        ST_DN_VDD  = 4'd9
    } state_e;

    // Everything the sequencer drives to the switches, decoded per state.
    typedef struct packed {
        logic vdd;
        logic vdda;
        logic vref;
        logic iso;
        logic rst;
        logic ack;
        logic busy;
    } outs_t;

    localparam outs_t C_OUT_OFF     = '{vdd:1'b0, vdda:1'b0, vref:1'b0, iso:1'b1, rst:1'b1, ack:1'b0, busy:1'b0};
    localparam outs_t C_OUT_UP_VDD  = '{vdd:1'b1, vdda:1'b0, vref:1'b0, iso:1'b1, rst:1'b1, ack:1'b0, busy:1'b1};
    localparam outs_t C_OUT_UP_VDDA = '{vdd:1'b1, vdda:1'b1, vref:1'b0, iso:1'b1, rst:1'b1, ack:1'b0, busy:1'b1};
    localparam outs_t C_OUT_UP_VREF = '{vdd:1'b1, vdda:1'b1, vref:1'b1, iso:1'b1, rst:1'b1, ack:1'b0, busy:1'b1};
    localparam outs_t C_OUT_UP_ISO  = '{vdd:1'b1, vdda:1'b1, vref:1'b1, iso:1'b0, rst:1'b0, ack:1'b0, busy:1'b1};
    localparam outs_t C_OUT_ON      = '{vdd:1'b1, vdda:1'b1, vref:1'b1, iso:1'b0, rst:1'b0, ack:1'b1, busy:1'b0};
    localparam outs_t C_OUT_DN_ISO  = '{vdd:1'b1, vdda:1'b1, vref:1'b1, iso:1'b1, rst:1'b1, ack:1'b0, busy:1'b1};
    localparam outs_t C_OUT_DN_VREF = '{vdd:1'b1, vdda:1'b1, vref:1'b0, iso:1'b1, rst:1'b1, ack:1'b0, busy:1'b1};
    localparam outs_t C_OUT_DN_VDDA = '{vdd:1'b1, vdda:1'b0, vref:1'b0, iso:1'b1, rst:1'b1, ack:1'b0, busy:1'b1};
    localparam outs_t C_OUT_DN_VDD  = '{vdd:1'b0, vdda:1'b0, vref:1'b0, iso:1'b1, rst:1'b1, ack:1'b0, busy:1'b1};

    function automatic outs_t state_decode(input state_e st);
        outs_t o;
        case (st)
            ST_OFF:     o = C_OUT_OFF;
            ST_UP_VDD:  o = C_OUT_UP_VDD;
            ST_UP_VDDA: o = C_OUT_UP_VDDA;
            ST_UP_VREF: o = C_OUT_UP_VREF;
            ST_UP_ISO:  o = C_OUT_UP_ISO;
            ST_ON:      o = C_OUT_ON;
            ST_DN_ISO:  o = C_OUT_DN_ISO;
            ST_DN_VREF: o = C_OUT_DN_VREF;
            ST_DN_VDDA: o = C_OUT_DN_VDDA;
            ST_DN_VDD:  o = C_OUT_DN_VDD;
            default:    o = C_OUT_OFF;
        endcase
        return o;
    endfunction

    // OFF and ON are the only states that wait on the request, not a timer.
    function automatic logic is_timed(input state_e st);
        return (st != ST_OFF) && (st != ST_ON);
    endfunction

endpackage : mram_pwr_pkg
`default_nettype wire

// File: rtl/mram_pwr_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mram_pwr_seq_if
//  Description : Bundle between the LLFSM / debug controls and the MRAM
//                power sequencer. master = requester side, slave = sequencer.
//  Signals     : pwr_req_i, ext_pg_mram_i, hold_i, step_mode_i, step_i,
//                cfg_t_{vdd,vdda,vref,iso}_i (requester -> sequencer);
//                vdd_en_o, vdda_en_o, vref_en_o, iso_o, mram_rst_o,
//                pwr_ack_o, busy_o, state_o (sequencer -> requester)
//  Revision    : 1.0  initial release
// ============================================================================
interface mram_pwr_seq_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 pwr_req_i;
    logic                 ext_pg_mram_i;
    logic                 hold_i;
    logic                 step_mode_i;
    logic                 step_i;
    logic [CNT_WIDTH-1:0] cfg_t_vdd_i;
    logic [CNT_WIDTH-1:0] cfg_t_vdda_i;
    logic [CNT_WIDTH-1:0] cfg_t_vref_i;
    logic [CNT_WIDTH-1:0] cfg_t_iso_i;
    logic                 vdd_en_o;
    logic                 vdda_en_o;
    logic                 vref_en_o;
    logic                 iso_o;
    logic                 mram_rst_o;
    logic                 pwr_ack_o;
    logic                 busy_o;
    logic [3:0]           state_o;

    modport master (
        output pwr_req_i, ext_pg_mram_i, hold_i, step_mode_i, step_i,
        output cfg_t_vdd_i, cfg_t_vdda_i, cfg_t_vref_i, cfg_t_iso_i,
        input  vdd_en_o, vdda_en_o, vref_en_o, iso_o, mram_rst_o,
        input  pwr_ack_o, busy_o, state_o
    );

    modport slave (
        input  pwr_req_i, ext_pg_mram_i, hold_i, step_mode_i, step_i,
        input  cfg_t_vdd_i, cfg_t_vdda_i, cfg_t_vref_i, cfg_t_iso_i,
        output vdd_en_o, vdda_en_o, vref_en_o, iso_o, mram_rst_o,
        output pwr_ack_o, busy_o, state_o
    );
endinterface : mram_pwr_seq_if
`default_nettype wire

// File: rtl/mram_pwr_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mram_pwr_timer
//  Description : Loadable CNT_WIDTH down-counter. Load has priority, hold
//                freezes the count, the count saturates at zero.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_load          load i_load_val this cycle
//                i_load_val      value loaded on i_load
//                i_hold          freeze the count
//                o_zero          count currently reads zero
//  Revision    : 1.0  initial release
// ============================================================================
module mram_pwr_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_load,
    input  wire logic [CNT_WIDTH-1:0] i_load_val,
    input  wire logic                 i_hold,
    output logic                      o_zero
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (!i_hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : mram_pwr_timer
`default_nettype wire

// File: rtl/mram_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mram_pwr_seq
//  Description : MRAM power-rail sequencer. Walks VDD -> VDDA -> VREF ->
//                isolation/reset release on power-up and the exact reverse
//                on power-down, each step lasting cfg+1 cycles. Answers a
//                4-phase req/ack handshake; ext_pg_mram_i forces power-off.
//  Ports       : clk_i, rst_i    clock, synchronous active-high reset
//                bus             mram_pwr_seq_if.slave (request, debug,
//                                step delays, rail enables, status)
//  Options     : MRAM_PWR_SEQ_STEP_EN  enables hold_i / step_mode_i / step_i
//                                      debug; when undefined they are ignored
//  Revision    : 1.0  initial release
// ============================================================================
module mram_pwr_seq
    import mram_pwr_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    mram_pwr_seq_if.slave bus
);

    state_e               r_state;
    state_e               w_next;
    outs_t                r_outs;
    logic                 w_eff;
    logic                 w_zero;
    logic                 w_hold;
    logic                 w_adv;
    logic                 w_load;
    logic [CNT_WIDTH-1:0] w_load_val;

    assign w_eff = bus.pwr_req_i & ~bus.ext_pg_mram_i;

`ifdef MRAM_PWR_SEQ_STEP_EN
    // Two-stage capture of the debug step pulse; the edge is seen one cycle
    // after step_i is first sampled high.
    logic r_step_q;
    logic r_step_q2;
    logic w_step_edge;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_step_q  <= 1'b0;
            r_step_q2 <= 1'b0;
        end else begin
            r_step_q  <= bus.step_i;
            r_step_q2 <= r_step_q;
        end
    end

    assign w_step_edge = r_step_q & ~r_step_q2;
    assign w_hold      = bus.hold_i;
    // In step mode the timer is bypassed: only a step edge leaves a timed state.
    assign w_adv       = ~w_hold & (bus.step_mode_i ? w_step_edge : w_zero);
`else
    logic w_unused_dbg;
    assign w_unused_dbg = bus.hold_i ^ bus.step_mode_i ^ bus.step_i;
    assign w_hold       = 1'b0;
    assign w_adv        = w_zero;
`endif

    // Next state. Power-up steps abort to their mirror; power-down always
    // runs to completion before a new request is honoured.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF:     if (w_eff)  w_next = ST_UP_VDD;
            ST_UP_VDD:  if (!w_eff) w_next = ST_DN_VDD;
                        else if (w_adv) w_next = ST_UP_VDDA;
            ST_UP_VDDA: if (!w_eff) w_next = ST_DN_VDDA;
                        else if (w_adv) w_next = ST_UP_VREF;
            ST_UP_VREF: if (!w_eff) w_next = ST_DN_VREF;
                        else if (w_adv) w_next = ST_UP_ISO;
            ST_UP_ISO:  if (!w_eff) w_next = ST_DN_ISO;
                        else if (w_adv) w_next = ST_ON;
            ST_ON:      if (!w_eff) w_next = ST_DN_ISO;
            ST_DN_ISO:  if (w_adv)  w_next = ST_DN_VREF;
            ST_DN_VREF: if (w_adv)  w_next = ST_DN_VDDA;
            ST_DN_VDDA: if (w_adv)  w_next = ST_DN_VDD;
            ST_DN_VDD:  if (w_adv)  w_next = ST_OFF;
            default:                w_next = ST_OFF;
        endcase
    end

    // The delay is captured only when a timed state is entered, so cfg
    // changes while a step is running do not disturb it.
    always_comb begin
        w_load_val = '0;
        case (w_next)
            ST_UP_VDD,  ST_DN_VDD:  w_load_val = bus.cfg_t_vdd_i;
            ST_UP_VDDA, ST_DN_VDDA: w_load_val = bus.cfg_t_vdda_i;
            ST_UP_VREF, ST_DN_VREF: w_load_val = bus.cfg_t_vref_i;
            ST_UP_ISO,  ST_DN_ISO:  w_load_val = bus.cfg_t_iso_i;
            default:                w_load_val = '0;
        endcase
    end

    assign w_load = (w_next != r_state) && is_timed(w_next);

    mram_pwr_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_hold     (w_hold),
        .o_zero     (w_zero)
    );

    // State and decoded outputs share one register stage so they always
    // change on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_OFF;
            r_outs  <= C_OUT_OFF;
        end else begin
            r_state <= w_next;
            r_outs  <= state_decode(w_next);
        end
    end

    assign bus.vdd_en_o   = r_outs.vdd;
    assign bus.vdda_en_o  = r_outs.vdda;
    assign bus.vref_en_o  = r_outs.vref;
    assign bus.iso_o      = r_outs.iso;
    assign bus.mram_rst_o = r_outs.rst;
    assign bus.pwr_ack_o  = r_outs.ack;
    assign bus.busy_o     = r_outs.busy;
    assign bus.state_o    = r_state;

endmodule : mram_pwr_seq
`default_nettype wire

// File: tb/tb_mram_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mram_pwr_seq
//  Description : Scoreboard bench for mram_pwr_seq. Stimulus pushes the
//                expected (cycle, state) of every state change; a monitor
//                pops on each observed change and checks timing, state and
//                the full output decode.
//  Options     : MRAM_PWR_SEQ_STEP_EN adds the step-debug scenario
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mram_pwr_seq;

    localparam int CW = 8;

    typedef struct packed {
        int         cyc;
        logic [3:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mram_pwr_seq_if #(.CNT_WIDTH(CW)) bus();

    mram_pwr_seq #(.CNT_WIDTH(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    logic       mon_en   = 1'b0;
    logic [3:0] prev_st  = 4'd0;
    exp_t       q[$];
    exp_t       e;

    always @(posedge clk) cyc <= cyc + 1;

    // {vdd, vdda, vref, iso, rst, ack, busy} expected in each state
    function automatic logic [6:0] exp_out(input logic [3:0] s);
        case (s)
            4'd0: return 7'b0001100;
            4'd1: return 7'b1001101;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111101;
            4'd4: return 7'b1110001;
            4'd5: return 7'b1110010;
            4'd6: return 7'b1111101;
            4'd7: return 7'b1101101;
            4'd8: return 7'b1001101;
            4'd9: return 7'b0001101;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic logic [6:0] act_out();
        return {bus.vdd_en_o, bus.vdda_en_o, bus.vref_en_o, bus.iso_o,
                bus.mram_rst_o, bus.pwr_ack_o, bus.busy_o};
    endfunction

    task automatic push(input int at, input logic [3:0] s);
        q.push_back('{cyc: at, st: s});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, expv, cyc);
        end
    endtask

    // Monitor: every state change must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && (bus.state_o !== prev_st)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_transition actual_state=%0d prev_state=%0d cycle=%0d",
                         bus.state_o, prev_st, cyc);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || bus.state_o !== e.st || act_out() !== exp_out(e.st)) begin
                    failures++;
                    $display("FAIL transition actual: cycle=%0d state=%0d outs=%b required: cycle=%0d state=%0d outs=%b",
                             cyc, bus.state_o, act_out(), e.cyc, e.st, exp_out(e.st));
                end
            end
            prev_st = bus.state_o;
        end
    end

    initial begin
        int c;
        bus.pwr_req_i     = 1'b0;
        bus.ext_pg_mram_i = 1'b0;
        bus.hold_i        = 1'b0;
        bus.step_mode_i   = 1'b0;
        bus.step_i        = 1'b0;
        bus.cfg_t_vdd_i   = '0;
        bus.cfg_t_vdda_i  = '0;
        bus.cfg_t_vref_i  = '0;
        bus.cfg_t_iso_i   = '0;

        tick(3);
        chk("reset_state", {28'd0, bus.state_o}, 32'd0);
        chk("reset_outs",  {25'd0, act_out()},   {25'd0, 7'b0001100});
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // all delays zero: one cycle per step, up then down
        c = cyc; bus.pwr_req_i = 1'b1;
        push(c+1, 1); push(c+2, 2); push(c+3, 3); push(c+4, 4); push(c+5, 5);
        tick(8);
        chk("ack_on_min", {31'd0, bus.pwr_ack_o}, 32'd1);
        c = cyc; bus.pwr_req_i = 1'b0;
        push(c+1, 6); push(c+2, 7); push(c+3, 8); push(c+4, 9); push(c+5, 0);
        tick(8);

        // VDDA delay 10; a mid-step cfg change must not alter the step
        bus.cfg_t_vdda_i = 8'd10;
        c = cyc; bus.pwr_req_i = 1'b1;
        push(c+1, 1); push(c+2, 2); push(c+13, 3); push(c+14, 4); push(c+15, 5);
        tick(5);
        bus.cfg_t_vdda_i = 8'd3;
        tick(15);
        bus.cfg_t_vdda_i = 8'd10;
        c = cyc; bus.pwr_req_i = 1'b0;
        push(c+1, 6); push(c+2, 7); push(c+3, 8); push(c+14, 9); push(c+15, 0);
        tick(18);
        bus.cfg_t_vdda_i = '0;

        // external override during UP_VREF aborts to DN_VREF
        bus.cfg_t_vref_i = 8'd5;
        c = cyc; bus.pwr_req_i = 1'b1;
        push(c+1, 1); push(c+2, 2); push(c+3, 3);
        tick(4);
        bus.ext_pg_mram_i = 1'b1;
        push(c+5, 7); push(c+11, 8); push(c+12, 9); push(c+13, 0);
        tick(14);
        chk("ovr_ack_low", {31'd0, bus.pwr_ack_o}, 32'd0);
        chk("ovr_state",   {28'd0, bus.state_o},   32'd0);
        bus.pwr_req_i = 1'b0; bus.ext_pg_mram_i = 1'b0; bus.cfg_t_vref_i = '0;
        tick(3);

        // early request drop in UP_VDDA aborts to DN_VDDA with reload
        bus.cfg_t_vdda_i = 8'd3;
        c = cyc; bus.pwr_req_i = 1'b1;
        push(c+1, 1); push(c+2, 2);
        tick(3);
        bus.pwr_req_i = 1'b0;
        push(c+4, 8); push(c+8, 9); push(c+9, 0);
        tick(12);

        // request re-raised during DN_VDDA: finish down, then restart
        bus.cfg_t_vdda_i = 8'd4;
        c = cyc; bus.pwr_req_i = 1'b1;
        push(c+1, 1); push(c+2, 2); push(c+7, 3); push(c+8, 4); push(c+9, 5);
        tick(12);
        c = cyc; bus.pwr_req_i = 1'b0;
        push(c+1, 6); push(c+2, 7); push(c+3, 8);
        tick(4);
        bus.pwr_req_i = 1'b1;
        push(c+8, 9); push(c+9, 0); push(c+10, 1); push(c+11, 2);
        push(c+16, 3); push(c+17, 4); push(c+18, 5);
        tick(20);
        c = cyc; bus.pwr_req_i = 1'b0;
        push(c+1, 6); push(c+2, 7); push(c+3, 8); push(c+8, 9); push(c+9, 0);
        tick(12);
        bus.cfg_t_vdda_i = '0;

        // maximum delay: VDD steps last 256 cycles
        bus.cfg_t_vdd_i = 8'd255;
        c = cyc; bus.pwr_req_i = 1'b1;
        push(c+1, 1); push(c+257, 2); push(c+258, 3); push(c+259, 4); push(c+260, 5);
        tick(265);
        c = cyc; bus.pwr_req_i = 1'b0;
        push(c+1, 6); push(c+2, 7); push(c+3, 8); push(c+4, 9); push(c+260, 0);
        tick(265);
        bus.cfg_t_vdd_i = '0;

        // reset asserted in UP_ISO returns to OFF with reset outputs
        bus.cfg_t_iso_i = 8'd6;
        c = cyc; bus.pwr_req_i = 1'b1;
        push(c+1, 1); push(c+2, 2); push(c+3, 3); push(c+4, 4);
        tick(5);
        rst = 1'b1;
        push(c+6, 0);
        tick(1);
        chk("rst_mid_state", {28'd0, bus.state_o}, 32'd0);
        chk("rst_mid_outs",  {25'd0, act_out()},   {25'd0, 7'b0001100});
        rst = 1'b0; bus.pwr_req_i = 1'b0; bus.cfg_t_iso_i = '0;
        tick(3);

`ifdef MRAM_PWR_SEQ_STEP_EN
        // step mode: timers ignored, one state per step pulse
        bus.step_mode_i  = 1'b1;
        bus.cfg_t_vdd_i  = 8'd255;
        bus.cfg_t_vdda_i = 8'd255;
        bus.cfg_t_vref_i = 8'd255;
        bus.cfg_t_iso_i  = 8'd255;
        c = cyc; bus.pwr_req_i = 1'b1;
        push(c+1, 1);
        tick(310);
        chk("step_hold", {28'd0, bus.state_o}, 32'd1);
        for (int k = 2; k <= 5; k++) begin
            c = cyc; bus.step_i = 1'b1;
            push(c+2, 4'(k));
            tick(2);
            bus.step_i = 1'b0;
            tick(3);
        end
        bus.step_mode_i  = 1'b0;
        bus.cfg_t_vdd_i  = '0;
        bus.cfg_t_vdda_i = '0;
        bus.cfg_t_vref_i = '0;
        bus.cfg_t_iso_i  = '0;
        c = cyc; bus.pwr_req_i = 1'b0;
        push(c+1, 6); push(c+2, 7); push(c+3, 8); push(c+4, 9); push(c+5, 0);
        tick(8);
`endif

        tick(2);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mram_pwr_seq
`default_nettype wire
